// File: rtl/video_chip_pm.sv
// Parametrised VGA shadow-RAM renderer: 1bpp/2bpp bitmap window, 4-entry palette, border, scroll start.
// Optional VIDEO_SCANLINE_EN halves every colour channel of window/border pixels on odd lines.
module video_chip_pm #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int RAM_AW   = 13,
    parameter int WIN_X0   = 64,
    parameter int WIN_Y0   = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  graphics_mode,
    input  logic        reg_cs,
    input  logic        mem_cs,
    input  logic        we,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    output logic [8:0]  rgb,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] X0     = 16'(WIN_X0);
    localparam logic [15:0] Y0     = 16'(WIN_Y0);
    localparam logic        SYNC_ON = 1'(SYNC_POL);

    localparam logic [1:0] RG_BLANK  = 2'd0;
    localparam logic [1:0] RG_BORDER = 2'd1;
    localparam logic [1:0] RG_WIN    = 2'd2;

    // S0: raster counters
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    // CPU-visible registers and the video RAM shadow
    logic [8:0]        r_palette [0:3];
    logic [8:0]        r_border;
    logic [RAM_AW-1:0] r_start;
    logic [7:0]        r_vid_ram [0:(2**RAM_AW)-1];

    // Pipeline stage registers
    logic [RAM_AW-1:0] r_p1_addr;
    logic [1:0]        r_p1_region;
    logic [2:0]        r_p1_sel;
    logic              r_p1_bpp;
    logic              r_p1_odd;
    logic              r_p1_hs;
    logic              r_p1_vs;

    logic [7:0]        r_ram_q;
    logic [1:0]        r_p2_region;
    logic [2:0]        r_p2_sel;
    logic              r_p2_bpp;
    logic              r_p2_odd;
    logic              r_p2_hs;
    logic              r_p2_vs;

    // Combinational decode
    logic [15:0]       w_h;
    logic [15:0]       w_v;
    logic [15:0]       w_dx;
    logic [15:0]       w_dy;
    logic [15:0]       w_wy;
    logic [15:0]       w_vlim;
    logic              w_active;
    logic              w_in_x;
    logic              w_in_y;
    logic [1:0]        w_region;
    logic [2:0]        w_sel;
    logic [RAM_AW-1:0] w_addr;
    logic              w_hs;
    logic              w_vs;
    logic [8:0]        w_reg_color;
    logic [RAM_AW-1:0] w_start_wr;
    logic [7:0]        w_shift;
    logic [1:0]        w_idx;
    logic [8:0]        w_pix;
    logic              w_dim;
    logic              w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign w_h      = 16'(r_h_cnt);
    assign w_v      = 16'(r_v_cnt);
    assign w_dx     = w_h - X0;
    assign w_dy     = w_v - Y0;
    assign w_vlim   = 16'd192 << graphics_mode[1:0];
    assign w_active = (w_h < H_ACT) && (w_v < V_ACT);
    assign w_in_x   = (w_h >= X0) && (w_dx < 16'd512);
    assign w_in_y   = (w_v >= Y0) && (w_dy < w_vlim);
    assign w_region = !w_active ? RG_BLANK : ((w_in_x && w_in_y) ? RG_WIN : RG_BORDER);

    // 32 bytes per logical row; the sum wraps naturally at the RAM size
    assign w_wy   = w_dy >> graphics_mode[1:0];
    assign w_addr = r_start + RAM_AW'({w_wy, 5'b0}) + RAM_AW'(w_dx[8:4]);

    // Low bit index of the pixel inside its byte: 7-x for 1bpp, (3-x)*2 for 2bpp
    assign w_sel = graphics_mode[3] ? {~w_dx[3:2], 1'b0} : ~w_dx[3:1];

    assign w_hs = ((w_h >= HS_BEG) && (w_h < HS_END)) ? SYNC_ON : ~SYNC_ON;
    assign w_vs = ((w_v >= VS_BEG) && (w_v < VS_END)) ? SYNC_ON : ~SYNC_ON;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p1_addr   <= '0;
            r_p1_region <= RG_BLANK;
            r_p1_sel    <= '0;
            r_p1_bpp    <= 1'b0;
            r_p1_odd    <= 1'b0;
            r_p1_hs     <= ~SYNC_ON;
            r_p1_vs     <= ~SYNC_ON;
        end else begin
            r_p1_addr   <= w_addr;
            r_p1_region <= w_region;
            r_p1_sel    <= w_sel;
            r_p1_bpp    <= graphics_mode[3];
            r_p1_odd    <= r_v_cnt[0];
            r_p1_hs     <= w_hs;
            r_p1_vs     <= w_vs;
        end
    end

    // Read and write share one process so a same-cycle read sees the old byte
    always_ff @(posedge clk) begin
        if (mem_cs && we) begin
            r_vid_ram[address[RAM_AW-1:0]] <= data;
        end
        r_ram_q <= r_vid_ram[r_p1_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p2_region <= RG_BLANK;
            r_p2_sel    <= '0;
            r_p2_bpp    <= 1'b0;
            r_p2_odd    <= 1'b0;
            r_p2_hs     <= ~SYNC_ON;
            r_p2_vs     <= ~SYNC_ON;
        end else begin
            r_p2_region <= r_p1_region;
            r_p2_sel    <= r_p1_sel;
            r_p2_bpp    <= r_p1_bpp;
            r_p2_odd    <= r_p1_odd;
            r_p2_hs     <= r_p1_hs;
            r_p2_vs     <= r_p1_vs;
        end
    end

    assign w_reg_color = {data[7:5], data[4:2], data[1:0], data[1]};
    assign w_start_wr  = RAM_AW'({data, 5'b0});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_palette[0] <= 9'b000000000;
            r_palette[1] <= 9'b010010010;
            r_palette[2] <= 9'b110110000;
            r_palette[3] <= 9'b110000000;
            r_border     <= 9'h000;
            r_start      <= '0;
        end else if (reg_cs && we) begin
            case (address[2:0])
                3'd0, 3'd1, 3'd2, 3'd3: r_palette[address[1:0]] <= w_reg_color;
                3'd4:                   r_border <= w_reg_color;
                3'd5:                   r_start <= w_start_wr;
                default: ;
            endcase
        end
    end

`ifdef VIDEO_SCANLINE_EN
    assign w_dim = r_p2_odd;
`else
    assign w_dim = 1'b0;
`endif

    assign w_shift = r_ram_q >> r_p2_sel;
    assign w_idx   = r_p2_bpp ? w_shift[1:0] : {1'b0, w_shift[0]};

    always_comb begin
        w_pix = 9'h000;
        case (r_p2_region)
            RG_WIN:    w_pix = r_palette[w_idx];
            RG_BORDER: w_pix = r_border;
            default:   w_pix = 9'h000;
        endcase
        if (w_dim) begin
            w_pix = {1'b0, w_pix[8:7], 1'b0, w_pix[5:4], 1'b0, w_pix[2:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb   <= 9'h000;
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
        end else begin
            rgb   <= w_pix;
            hsync <= r_p2_hs;
            vsync <= r_p2_vs;
        end
    end

    assign w_unused = ^{graphics_mode[2], address[15:RAM_AW], r_p2_odd};

endmodule

// File: tb/tb_video_chip_pm.sv
// Directed bench for video_chip_pm: pixel vector table plus sync-timing and mid-line reset sequences.
// Uses a shortened vertical frame (12 lines) so several frames fit in a short run.
module tb_video_chip_pm;

    localparam int H_TOT = 800;
    localparam int V_TOT = 12;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  graphics_mode;
    logic        reg_cs;
    logic        mem_cs;
    logic        we;
    logic [15:0] address;
    logic [7:0]  data;
    logic [8:0]  rgb;
    logic        hsync;
    logic        vsync;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         grp;
        logic [3:0] mode;
        int         h;
        int         v;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    video_chip_pm #(
        .V_ACTIVE(8),
        .V_FP    (1),
        .V_SYNC  (2),
        .V_BP    (1),
        .WIN_Y0  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .graphics_mode(graphics_mode),
        .reg_cs       (reg_cs),
        .mem_cs       (mem_cs),
        .we           (we),
        .address      (address),
        .data         (data),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    // Clock and cycle count since the last sampled reset (equals the raster position)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs lag the raster counters by three clocks
    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2 * FRAME && !ok; n++) begin
            @(negedge clk);
            if (cyc >= 3 && ((cyc - 3) % H_TOT) == h && (((cyc - 3) / H_TOT) % V_TOT) == v)
                ok = 1'b1;
        end
    endtask

    task automatic cpu_write(input bit is_reg, input int a, input logic [7:0] d);
        @(negedge clk);
        reg_cs  = is_reg;
        mem_cs  = !is_reg;
        we      = 1'b1;
        address = 16'(a);
        data    = d;
        @(negedge clk);
        reg_cs  = 1'b0;
        mem_cs  = 1'b0;
        we      = 1'b0;
    endtask

`ifdef VIDEO_SCANLINE_EN
    function automatic logic [8:0] dim(input logic [8:0] c, input int v);
        if (v % 2 == 1) return {1'b0, c[8:7], 1'b0, c[5:4], 1'b0, c[2:1]};
        return c;
    endfunction
`endif

    task automatic add(input int g, input logic [3:0] m, input int h, input int v, input logic [8:0] e);
        vec_t t;
        t.grp = g; t.mode = m; t.h = h; t.v = v; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic setup_group(input int g);
        case (g)
            0: begin cpu_write(0, 0, 8'h80); cpu_write(0, 1, 8'h01); end
            1: begin cpu_write(0, 0, 8'hE4); cpu_write(1, 3, 8'hFF); end
            2: cpu_write(1, 4, 8'h03);
            3: begin
                cpu_write(1, 5, 8'h01);
                for (int i = 32; i < 64; i++) cpu_write(0, i, 8'hFF);
            end
            default: begin cpu_write(1, 5, 8'hFF); cpu_write(0, 8191, 8'h01); end
        endcase
    endtask

    initial begin
        bit         ok;
        int         prev_grp;
        int         t0;
        logic [8:0] e;

        reset = 1'b1; graphics_mode = 4'b0000;
        reg_cs = 1'b0; mem_cs = 1'b0; we = 1'b0; address = '0; data = '0;
        repeat (5) @(negedge clk);
        check("reset_rgb", 32'(rgb), 0);
        check("reset_hsync", 32'(hsync), 1);
        check("reset_vsync", 32'(vsync), 1);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) cpu_write(0, i, 8'h00);
        for (int i = 8160; i < 8192; i++) cpu_write(0, i, 8'h00);

        // 1bpp, repeat 2: RAM0=80, RAM1=01
        add(0, 4'b0001, 64, 2, 9'h092); add(0, 4'b0001, 65, 2, 9'h092);
        add(0, 4'b0001, 66, 2, 9'h000); add(0, 4'b0001, 79, 2, 9'h000);
        add(0, 4'b0001, 93, 2, 9'h000); add(0, 4'b0001, 94, 2, 9'h092);
        add(0, 4'b0001, 64, 3, 9'h092); add(0, 4'b0001, 66, 3, 9'h000);
        add(0, 4'b0001, 64, 4, 9'h000);
        // 2bpp: RAM0=E4, palette3=1FF
        add(1, 4'b1000, 64, 2, 9'h1FF); add(1, 4'b1000, 67, 2, 9'h1FF);
        add(1, 4'b1000, 68, 2, 9'h1B0); add(1, 4'b1000, 72, 2, 9'h092);
        add(1, 4'b1000, 75, 2, 9'h092); add(1, 4'b1000, 76, 2, 9'h000);
        add(1, 4'b1000, 91, 2, 9'h000); add(1, 4'b1000, 92, 2, 9'h092);
        add(1, 4'b1000, 64, 3, 9'h000);
        // border=007, window edges, blanking, clipped lines
        add(2, 4'b1000, 100, 0, 9'h007); add(2, 4'b1000, 10, 2, 9'h007);
        add(2, 4'b1000, 63, 2, 9'h007);  add(2, 4'b1000, 64, 2, 9'h1FF);
        add(2, 4'b1000, 575, 2, 9'h000); add(2, 4'b1000, 576, 2, 9'h007);
        add(2, 4'b1000, 639, 7, 9'h007); add(2, 4'b1000, 640, 7, 9'h000);
        add(2, 4'b1000, 100, 8, 9'h000);
        // start=32 with RAM32..63=FF
        add(3, 4'b0000, 64, 2, 9'h092);  add(3, 4'b0000, 575, 2, 9'h092);
        add(3, 4'b0000, 576, 2, 9'h007); add(3, 4'b0000, 64, 3, 9'h000);
        // start=8160: row 1 wraps to RAM 0
        add(4, 4'b0000, 64, 2, 9'h000);  add(4, 4'b0000, 575, 2, 9'h092);
        add(4, 4'b0000, 64, 3, 9'h092);  add(4, 4'b0000, 70, 3, 9'h000);
        add(4, 4'b0000, 74, 3, 9'h092);

        prev_grp = -1;
        for (int i = 0; i < vecs.size(); i++) begin
            graphics_mode = vecs[i].mode;
            if (vecs[i].grp != prev_grp) begin
                setup_group(vecs[i].grp);
                repeat (4) @(negedge clk);
                prev_grp = vecs[i].grp;
            end
            e = vecs[i].exp;
`ifdef VIDEO_SCANLINE_EN
            e = dim(e, vecs[i].v);
`endif
            wait_pos(vecs[i].h, vecs[i].v, ok);
            if (!ok) check($sformatf("timeout g%0d h%0d v%0d", vecs[i].grp, vecs[i].h, vecs[i].v), 0, 1);
            else     check($sformatf("pix g%0d h%0d v%0d", vecs[i].grp, vecs[i].h, vecs[i].v), 32'(rgb), 32'(e));
        end

        // Mid-line reset while hsync is active: pipeline must flush
        ok = 1'b0;
        for (int n = 0; n < 2 * H_TOT && !ok; n++) begin
            @(negedge clk);
            if (cyc % H_TOT == 700) ok = 1'b1;
        end
        check("pre_reset_hsync_low", 32'(hsync), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush_rgb_%0d", k), 32'(rgb), 0);
            check($sformatf("flush_hsync_%0d", k), 32'(hsync), 1);
            check($sformatf("flush_vsync_%0d", k), 32'(vsync), 1);
            @(negedge clk);
        end

        // Sync timing measured from the restart at (0,0)
        while (hsync !== 1'b0 && cyc < 2000) @(negedge clk);
        check("hsync_first_fall", cyc, 659);
        t0 = cyc;
        while (hsync === 1'b0 && cyc < t0 + 2000) @(negedge clk);
        check("hsync_width", cyc - t0, 96);
        while (hsync !== 1'b0 && cyc < 4000) @(negedge clk);
        check("hsync_period", cyc, 659 + H_TOT);
        while (vsync !== 1'b0 && cyc < 2 * FRAME) @(negedge clk);
        check("vsync_first_fall", cyc, 9 * H_TOT + 3);
        t0 = cyc;
        while (vsync === 1'b0 && cyc < t0 + FRAME) @(negedge clk);
        check("vsync_width", cyc - t0, 2 * H_TOT);

        // Registers returned to reset values: border 0, start 0, palette3 180
        graphics_mode = 4'b1000;
        wait_pos(10, 0, ok);
        if (!ok) check("timeout border_reset", 0, 1);
        else     check("border_after_reset", 32'(rgb), 0);
        wait_pos(64, 2, ok);
        if (!ok) check("timeout palette_reset", 0, 1);
        else     check("palette3_after_reset", 32'(rgb), 32'h180);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
